// File: rtl/up_down_counter_n_if.sv
// Control and status bundle for up_down_counter_n: the user side drives the
// count controls and load value, the counter side returns Q and its flags.
interface up_down_counter_n_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             m;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             sat;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             ovf;

  // No handshake: every control is level-sampled on each rising edge, and
  // Q/ovf are valid for the whole cycle that follows.
  modport master (
    output en, m, load, d, sat,
    input  Q, tc, ovf
  );

  modport slave (
    input  en, m, load, d, sat,
    output Q, tc, ovf
  );
endinterface

// File: rtl/up_down_counter_n.sv
// Parametrised synchronous up/down counter with modulus, parallel load,
// enable, wrap-or-saturate bounds, a terminal-count flag and a bound-event pulse.
module up_down_counter_n #(
  parameter int WIDTH     = 3,
  parameter int MODULUS   = 2 ** WIDTH,
  parameter int RESET_VAL = 0
) (
  input  logic               clk,
  input  logic               clr,
  up_down_counter_n_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RESET_V = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic             ovf;
  logic             ovf_next;
  logic             at_top;
  logic             at_bot;

  // Bounds come from MODULUS rather than carry-out, so non-power-of-two
  // ranges wrap at MODULUS-1 instead of 2**WIDTH-1.
  assign at_top = (q == MAX_V);
  assign at_bot = (q == '0);

  always_comb begin
    q_next   = q;
    ovf_next = 1'b0;
    if (bus.load) begin
      q_next = (bus.d > MAX_V) ? MAX_V : bus.d;
    end else if (bus.en) begin
      if (!bus.m) begin
        if (at_top) begin
          q_next   = bus.sat ? q : '0;
          ovf_next = 1'b1;
        end else begin
          q_next = q + ONE_V;
        end
      end else begin
        if (at_bot) begin
          q_next   = bus.sat ? q : MAX_V;
          ovf_next = 1'b1;
        end else begin
          q_next = q - ONE_V;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q   <= RESET_V;
      ovf <= 1'b0;
    end else begin
      q   <= q_next;
      ovf <= ovf_next;
    end
  end

  // tc flags the cycle whose edge will produce the bound event.
  assign bus.tc  = bus.en & ~bus.load & (bus.m ? at_bot : at_top);
  assign bus.Q   = q;
  assign bus.ovf = ovf;

endmodule

// File: tb/tb_up_down_counter_n.sv
// Bench for up_down_counter_n: a default 3-bit instance and a WIDTH=4,
// MODULUS=10, RESET_VAL=3 instance share stimulus and are checked against models.
module tb_up_down_counter_n;

  localparam int MOD_A = 8;
  localparam int MOD_B = 10;
  localparam int RST_A = 0;
  localparam int RST_B = 3;

  logic       clk = 1'b0;
  logic       clr;
  logic       en, m, load, sat;
  logic [3:0] d;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state for both instances
  int qa, qb;
  bit oa, ob;

  always #5 clk = ~clk;

  up_down_counter_n_if #(.WIDTH(3)) bus_a ();
  up_down_counter_n_if #(.WIDTH(4)) bus_b ();

  assign bus_a.en   = en;
  assign bus_a.m    = m;
  assign bus_a.load = load;
  assign bus_a.sat  = sat;
  assign bus_a.d    = d[2:0];
  assign bus_b.en   = en;
  assign bus_b.m    = m;
  assign bus_b.load = load;
  assign bus_b.sat  = sat;
  assign bus_b.d    = d;

  up_down_counter_n u_a (
    .clk (clk),
    .clr (clr),
    .bus (bus_a)
  );

  up_down_counter_n #(
    .WIDTH     (4),
    .MODULUS   (MOD_B),
    .RESET_VAL (RST_B)
  ) u_b (
    .clk (clk),
    .clr (clr),
    .bus (bus_b)
  );

  // One edge of the counter, straight from the operation rules.
  function automatic void step_model(input int modulus, input int dv,
                                     inout int q, inout bit o);
    if (load) begin
      q = (dv < modulus) ? dv : modulus - 1;
      o = 1'b0;
    end else if (en) begin
      if (!m) begin
        if (q + 1 >= modulus) begin
          o = 1'b1;
          if (!sat) q = 0;
        end else begin
          q = q + 1;
          o = 1'b0;
        end
      end else begin
        if (q - 1 < 0) begin
          o = 1'b1;
          if (!sat) q = modulus - 1;
        end else begin
          q = q - 1;
          o = 1'b0;
        end
      end
    end else begin
      o = 1'b0;
    end
  endfunction

  function automatic bit model_tc(input int modulus, input int q);
    return en && !load && (m ? (q == 0) : (q == modulus - 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    if (clr) begin
      step_model(MOD_A, int'(d[2:0]), qa, oa);
      step_model(MOD_B, int'(d), qb, ob);
    end
    #1;
  endtask

  task automatic assert_clr();
    clr = 1'b0;
    qa = RST_A; oa = 1'b0;
    qb = RST_B; ob = 1'b0;
  endtask

  task automatic set_inputs(input bit e, input bit mm, input bit l, input bit s,
                            input logic [3:0] dv);
    en = e; m = mm; load = l; sat = s; d = dv;
  endtask

  task automatic test_reset();
    set_inputs(1'b1, 1'b0, 1'b1, 1'b0, 4'd6);
    assert_clr();
    #12;
    n_cmp++; if (bus_a.Q !== 3'(RST_A)) begin n_bad++; $display("FAIL reset_q_a: got %0d expected %0d", bus_a.Q, RST_A); end
    n_cmp++; if (bus_a.ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf_a: got %0b expected 0", bus_a.ovf); end
    n_cmp++; if (bus_b.Q !== 4'(RST_B)) begin n_bad++; $display("FAIL reset_q_b: got %0d expected %0d", bus_b.Q, RST_B); end
    n_cmp++; if (bus_b.ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf_b: got %0b expected 0", bus_b.ovf); end
  endtask

  task automatic test_up_wrap();
    int exp_seq[10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
    int prev;
    assert_clr();
    set_inputs(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    clr = 1'b1;
    prev = RST_A;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++; if (bus_a.tc !== (prev == 7)) begin n_bad++; $display("FAIL up_tc_a[%0d]: got %0b expected %0b", i, bus_a.tc, prev == 7); end
      tick();
      n_cmp++; if (bus_a.Q !== 3'(exp_seq[i])) begin n_bad++; $display("FAIL up_q_a[%0d]: got %0d expected %0d", i, bus_a.Q, exp_seq[i]); end
      n_cmp++; if (bus_a.ovf !== (exp_seq[i] == 0)) begin n_bad++; $display("FAIL up_ovf_a[%0d]: got %0b expected %0b", i, bus_a.ovf, exp_seq[i] == 0); end
      prev = exp_seq[i];
    end
  endtask

  task automatic test_down_wrap();
    int exp_seq[4] = '{1, 0, 9, 8};
    int prev;
    set_inputs(1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
    tick();
    n_cmp++; if (bus_b.Q !== 4'd2) begin n_bad++; $display("FAIL down_load_b: got %0d expected 2", bus_b.Q); end
    set_inputs(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    prev = 2;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if (bus_b.tc !== (prev == 0)) begin n_bad++; $display("FAIL down_tc_b[%0d]: got %0b expected %0b", i, bus_b.tc, prev == 0); end
      tick();
      n_cmp++; if (bus_b.Q !== 4'(exp_seq[i])) begin n_bad++; $display("FAIL down_q_b[%0d]: got %0d expected %0d", i, bus_b.Q, exp_seq[i]); end
      n_cmp++; if (bus_b.ovf !== (exp_seq[i] == 9)) begin n_bad++; $display("FAIL down_ovf_b[%0d]: got %0b expected %0b", i, bus_b.ovf, exp_seq[i] == 9); end
      prev = exp_seq[i];
    end
  endtask

  task automatic test_saturate();
    bit exp_ovf[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    set_inputs(1'b0, 1'b0, 1'b1, 1'b1, 4'd8);
    tick();
    n_cmp++; if (bus_b.Q !== 4'd8) begin n_bad++; $display("FAIL sat_load_b: got %0d expected 8", bus_b.Q); end
    set_inputs(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (bus_b.Q !== 4'd9) begin n_bad++; $display("FAIL sat_q_b[%0d]: got %0d expected 9", i, bus_b.Q); end
      n_cmp++; if (bus_b.ovf !== exp_ovf[i]) begin n_bad++; $display("FAIL sat_ovf_b[%0d]: got %0b expected %0b", i, bus_b.ovf, exp_ovf[i]); end
    end
    n_cmp++; if (bus_b.tc !== 1'b1) begin n_bad++; $display("FAIL sat_tc_b: got %0b expected 1", bus_b.tc); end
    m = 1'b1;
    #1;
    n_cmp++; if (bus_b.tc !== 1'b0) begin n_bad++; $display("FAIL rev_tc_b: got %0b expected 0", bus_b.tc); end
    tick();
    n_cmp++; if (bus_b.Q !== 4'd8) begin n_bad++; $display("FAIL rev_q_b: got %0d expected 8", bus_b.Q); end
    n_cmp++; if (bus_b.ovf !== 1'b0) begin n_bad++; $display("FAIL rev_ovf_b: got %0b expected 0", bus_b.ovf); end
  endtask

  task automatic test_load_clamp();
    set_inputs(1'b0, 1'b0, 1'b1, 1'b0, 4'd13);
    tick();
    n_cmp++; if (bus_b.Q !== 4'd9) begin n_bad++; $display("FAIL clamp_q_b: got %0d expected 9", bus_b.Q); end
    n_cmp++; if (bus_a.Q !== 3'd5) begin n_bad++; $display("FAIL load13_q_a: got %0d expected 5", bus_a.Q); end
    set_inputs(1'b1, 1'b0, 1'b1, 1'b0, 4'd4);
    #1;
    n_cmp++; if (bus_b.tc !== 1'b0) begin n_bad++; $display("FAIL load_tc_b: got %0b expected 0", bus_b.tc); end
    tick();
    n_cmp++; if (bus_b.Q !== 4'd4) begin n_bad++; $display("FAIL load_en_q_b: got %0d expected 4", bus_b.Q); end
    n_cmp++; if (bus_b.ovf !== 1'b0) begin n_bad++; $display("FAIL load_en_ovf_b: got %0b expected 0", bus_b.ovf); end
  endtask

  task automatic test_hold();
    set_inputs(1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m = i[0];
      #1;
      n_cmp++; if (bus_b.tc !== 1'b0) begin n_bad++; $display("FAIL hold_tc_b[%0d]: got %0b expected 0", i, bus_b.tc); end
      tick();
      n_cmp++; if (bus_a.Q !== 3'd3) begin n_bad++; $display("FAIL hold_q_a[%0d]: got %0d expected 3", i, bus_a.Q); end
      n_cmp++; if (bus_b.Q !== 4'd3) begin n_bad++; $display("FAIL hold_q_b[%0d]: got %0d expected 3", i, bus_b.Q); end
      n_cmp++; if (bus_b.ovf !== 1'b0) begin n_bad++; $display("FAIL hold_ovf_b[%0d]: got %0b expected 0", i, bus_b.ovf); end
    end
  endtask

  task automatic test_async_reset();
    // Saturate B at 9 so ovf is high when reset lands mid-cycle
    set_inputs(1'b0, 1'b0, 1'b1, 1'b1, 4'd9);
    tick();
    set_inputs(1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
    tick();
    n_cmp++; if (bus_b.ovf !== 1'b1) begin n_bad++; $display("FAIL pre_rst_ovf_b: got %0b expected 1", bus_b.ovf); end
    #2;
    assert_clr();
    #1;
    n_cmp++; if (bus_b.Q !== 4'(RST_B)) begin n_bad++; $display("FAIL async_q_b: got %0d expected %0d", bus_b.Q, RST_B); end
    n_cmp++; if (bus_b.ovf !== 1'b0) begin n_bad++; $display("FAIL async_ovf_b: got %0b expected 0", bus_b.ovf); end
    n_cmp++; if (bus_a.Q !== 3'(RST_A)) begin n_bad++; $display("FAIL async_q_a: got %0d expected %0d", bus_a.Q, RST_A); end
    load = 1'b1; d = 4'd7;
    tick();
    n_cmp++; if (bus_b.Q !== 4'(RST_B)) begin n_bad++; $display("FAIL held_rst_q_b: got %0d expected %0d", bus_b.Q, RST_B); end
    load = 1'b0; sat = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    tick();
    n_cmp++; if (bus_b.Q !== 4'(RST_B + 1)) begin n_bad++; $display("FAIL release_q_b: got %0d expected %0d", bus_b.Q, RST_B + 1); end
    n_cmp++; if (bus_a.Q !== 3'(RST_A + 1)) begin n_bad++; $display("FAIL release_q_a: got %0d expected %0d", bus_a.Q, RST_A + 1); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_inputs($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 39) == 0) begin
        #3;
        assert_clr();
        #1;
        n_cmp++; if (bus_b.Q !== 4'(qb)) begin n_bad++; $display("FAIL rnd_rst_q_b[%0d]: got %0d expected %0d", i, bus_b.Q, qb); end
        tick();
        @(negedge clk);
        clr = 1'b1;
      end
      #2;
      n_cmp++; if (bus_a.tc !== model_tc(MOD_A, qa)) begin n_bad++; $display("FAIL rnd_tc_a[%0d]: got %0b expected %0b", i, bus_a.tc, model_tc(MOD_A, qa)); end
      n_cmp++; if (bus_b.tc !== model_tc(MOD_B, qb)) begin n_bad++; $display("FAIL rnd_tc_b[%0d]: got %0b expected %0b", i, bus_b.tc, model_tc(MOD_B, qb)); end
      tick();
      n_cmp++; if (bus_a.Q !== 3'(qa)) begin n_bad++; $display("FAIL rnd_q_a[%0d]: got %0d expected %0d", i, bus_a.Q, qa); end
      n_cmp++; if (bus_a.ovf !== oa) begin n_bad++; $display("FAIL rnd_ovf_a[%0d]: got %0b expected %0b", i, bus_a.ovf, oa); end
      n_cmp++; if (bus_b.Q !== 4'(qb)) begin n_bad++; $display("FAIL rnd_q_b[%0d]: got %0d expected %0d", i, bus_b.Q, qb); end
      n_cmp++; if (bus_b.ovf !== ob) begin n_bad++; $display("FAIL rnd_ovf_b[%0d]: got %0b expected %0b", i, bus_b.ovf, ob); end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_saturate();
    test_load_clamp();
    test_hold();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/up_down_counter_n.md
# up_down_counter_n

Parametrised synchronous up/down counter: the next-generation successor to the team's 3-bit up/down counter. It adds configurable width and modulus, a synchronous parallel load, a count enable, wrap-or-saturate selection, and terminal-count and overflow flags. All state bits share one clock; there is no ripple clocking. It serves as the general counter primitive for lab datapaths, including timers, address generators and modulo-N dividers.

## Interface
- WIDTH, 3: counter width in bits, 1 or more.
- MODULUS, 2**WIDTH: count range is 0..MODULUS-1; legal values are 2..2**WIDTH.
- RESET_VAL, 0: value of Q after reset; must be less than MODULUS.

- clk  input  1  clock; all state updates on the rising edge.
- clr  input  1  reset, asynchronous, active-low.
- en  input  1  count enable.
- m  input  1  direction: 0 = up, 1 = down.
- load  input  1  synchronous parallel load.
- d  input  WIDTH  load value.
- sat  input  1  bound behaviour: 0 = wrap, 1 = saturate.
- Q  output  WIDTH  current count (registered).
- tc  output  1  terminal count (combinational).
- ovf  output  1  bound-event pulse (registered).

## Operation
- Reset (clr=0): Q = RESET_VAL and ovf = 0 immediately, without waiting for a clock edge. All inputs are ignored while clr=0.
- Priority at each rising edge: load, then en, then hold.
- Load (load=1):
  - Q <= d if d < MODULUS; otherwise Q <= MODULUS-1 (clamp).
  - en, m and sat are ignored that cycle.
  - ovf <= 0.
- Count (load=0, en=1, m=0, up):
  - If Q < MODULUS-1: Q <= Q+1.
  - If Q = MODULUS-1 and sat=0: Q <= 0, ovf <= 1.
  - If Q = MODULUS-1 and sat=1: Q holds, ovf <= 1.
- Count (load=0, en=1, m=1, down):
  - If Q > 0: Q <= Q-1.
  - If Q = 0 and sat=0: Q <= MODULUS-1, ovf <= 1.
  - If Q = 0 and sat=1: Q holds, ovf <= 1.
- Hold (load=0, en=0): Q holds, ovf <= 0.
- Arithmetic width rules:
  - Next-state arithmetic uses WIDTH bits.
  - Bound comparisons use the MODULUS constant, never natural overflow. Natural overflow matters only when MODULUS = 2**WIDTH, where the results are identical.
- tc = en & ~load & (m ? (Q==0) : (Q==MODULUS-1)). It is high during exactly the cycle whose rising edge produces the bound event.
- Direction change: m is sampled each edge with no pipeline. Reversing direction at a bound (for example Q=MODULUS-1 with m going to 1) counts normally and sets no ovf.
- ovf is a single-cycle pulse per bound event. It stays high on consecutive cycles while saturated and enabled.

## Timing
- Count latency: one clock edge from en to Q.
- Load latency: one edge from load to Q.
- tc is combinational from Q, en, load and m, with zero latency.
- ovf is high during the cycle after the edge that caused the wrap or saturation, coincident with the new Q.
- Reset assertion is asynchronous. Deassertion takes effect at the first rising edge after clr goes high; the first count or load happens on that edge if en or load is high. The source of clr is responsible for synchronising its deassertion.
- No combinational path from any input to Q or ovf.
- Reset mid-operation: Q and ovf return to their reset values regardless of a pending load or count. No state survives reset.

## Test plan
- Default parameters, clr pulsed low then high, en=1, m=0, sat=0 for 10 edges -> Q sequence 1,2,…,7,0,1,2. ovf high only in the cycle Q=0; tc high while Q=7.
- MODULUS=10, WIDTH=4, m=1, sat=0, load d=2 then count 4 edges -> Q 2,1,0,9,8. ovf high with Q=9; tc high while Q=0.
- MODULUS=10, sat=1, load d=8, m=0, count 4 edges -> Q 8,9,9,9,9. ovf high on the three cycles after reaching 9. Then m=1 for one edge -> Q=8, ovf=0.
- MODULUS=10, load d=13 -> Q=9 (clamped). Apply load=1 and en=1 together with d=4 -> Q=4, no count applied.
- Mid-count at Q=5 (en=1), drive clr low between clock edges -> Q=RESET_VAL and ovf=0 before the next edge. Release clr with en=1 -> Q=RESET_VAL+1 on the first edge after release.
- en=0 for 5 edges from Q=3 -> Q stays 3, ovf=0, tc=0 regardless of m.
